// File: rtl/branch_pc_if.sv
// Branch/PC bundle between decode-execute and the fetch PC unit.
// master drives branch/jump/stall requests and observes the fetch PC,
// target and flush; slave is the PC unit itself.
interface branch_pc_if #(
  parameter int WIDTH     = 16,
  parameter int OFF_WIDTH = 16,
  parameter int CNT_WIDTH = 8
);
  // requests toward the PC unit
  logic                 stall;
  logic                 br_valid;
  logic                 br_taken;
  logic [WIDTH-1:0]     br_pc;
  logic [OFF_WIDTH-1:0] br_offset;
  logic                 jmp_valid;
  logic [WIDTH-1:0]     jmp_addr;
  // results from the PC unit
  logic [WIDTH-1:0]     pc;
  logic [WIDTH-1:0]     pc_plus;
  logic [WIDTH-1:0]     target;
  logic                 target_valid;
  logic                 flush;
  logic [CNT_WIDTH-1:0] redirect_cnt;

  modport master (
    output stall, br_valid, br_taken, br_pc, br_offset, jmp_valid, jmp_addr,
    input  pc, pc_plus, target, target_valid, flush, redirect_cnt
  );

  modport slave (
    input  stall, br_valid, br_taken, br_pc, br_offset, jmp_valid, jmp_addr,
    output pc, pc_plus, target, target_valid, flush, redirect_cnt
  );
endinterface

// File: rtl/branch_pc_unit.sv
// Fetch PC register plus branch-target adder with one-cycle registered redirect.
// Latency: target/flush one edge after br_valid; taken-branch PC redirect two edges.
// No backpressure: stall only holds the sequential path; redirects always win.
//
// Ports: clk, rst (sync, active-high); bus (branch_pc_if.slave) carries
// stall/br_*/jmp_* requests in and pc, pc_plus, target, target_valid,
// flush, redirect_cnt out.
module branch_pc_unit #(
  parameter int               WIDTH     = 16,
  parameter int               OFF_WIDTH = 16,
  parameter int               OFF_SHIFT = 0,
  parameter int               INC       = 1,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int               CNT_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  branch_pc_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     pc_q;
  logic [WIDTH-1:0]     target_q;
  logic                 target_valid_q;
  logic [CNT_WIDTH-1:0] redirect_cnt_q;

  logic [WIDTH-1:0]     off_sext;
  logic [WIDTH-1:0]     br_sum;
  logic [WIDTH-1:0]     pc_plus;

  // Sign-extend through a signed cast so OFF_WIDTH == WIDTH needs no special case.
  assign off_sext = WIDTH'($signed(bus.br_offset));
  // Truncating add: wraps silently in both directions.
  assign br_sum   = bus.br_pc + (off_sext << OFF_SHIFT);
  assign pc_plus  = pc_q + WIDTH'(INC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      pc_q           <= RESET_PC;
      target_q       <= '0;
      target_valid_q <= 1'b0;
      redirect_cnt_q <= '0;
    end else if (state == PEND) begin
      // Redirect cycle: everything requested now is from the wrong path.
      state          <= IDLE;
      pc_q           <= target_q;
      target_valid_q <= 1'b0;
      if (redirect_cnt_q != '1) begin
        redirect_cnt_q <= redirect_cnt_q + 1'b1;
      end
    end else begin
      // Branch capture is independent of stall.
      if (bus.br_valid) begin
        target_q       <= br_sum;
        target_valid_q <= 1'b1;
        state          <= bus.br_taken ? PEND : IDLE;
      end else begin
        target_valid_q <= 1'b0;
      end

      if (bus.jmp_valid) begin
        pc_q <= bus.jmp_addr;
      end else if (!bus.stall) begin
        pc_q <= pc_plus;
      end
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_plus      = pc_plus;
  assign bus.target       = target_q;
  assign bus.target_valid = target_valid_q;
  assign bus.flush        = (state == PEND);
  assign bus.redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Bench for branch_pc_unit: two instances (unit addressing with 8-bit counter,
// word-scaled offsets with 2-bit counter) driven by identical stimulus and
// compared every cycle against a behavioural reference model.
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, br_valid, br_taken, jmp_valid;
  logic [15:0] br_pc, br_offset, jmp_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_pc_if #(.WIDTH(16), .OFF_WIDTH(16), .CNT_WIDTH(8)) if0 ();
  branch_pc_if #(.WIDTH(16), .OFF_WIDTH(16), .CNT_WIDTH(2)) if1 ();

  assign if0.stall = stall;     assign if1.stall = stall;
  assign if0.br_valid = br_valid; assign if1.br_valid = br_valid;
  assign if0.br_taken = br_taken; assign if1.br_taken = br_taken;
  assign if0.br_pc = br_pc;     assign if1.br_pc = br_pc;
  assign if0.br_offset = br_offset; assign if1.br_offset = br_offset;
  assign if0.jmp_valid = jmp_valid; assign if1.jmp_valid = jmp_valid;
  assign if0.jmp_addr = jmp_addr; assign if1.jmp_addr = jmp_addr;

  branch_pc_unit #(.WIDTH(16), .OFF_WIDTH(16), .OFF_SHIFT(0), .INC(1),
                   .RESET_PC(16'h0000), .CNT_WIDTH(8))
    dut0 (.clk(clk), .rst(rst), .bus(if0));

  branch_pc_unit #(.WIDTH(16), .OFF_WIDTH(16), .OFF_SHIFT(2), .INC(1),
                   .RESET_PC(16'h0000), .CNT_WIDTH(2))
    dut1 (.clk(clk), .rst(rst), .bus(if1));

  // Reference model: index 0 -> dut0, index 1 -> dut1.
  int scale[2] = '{1, 4};
  int cmax[2]  = '{255, 3};
  int m_pc[2], m_tgt[2], m_tv[2], m_pend[2], m_cnt[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step();
    int off;
    off = int'($signed(br_offset));
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_pc[k] = 0; m_tgt[k] = 0; m_tv[k] = 0; m_pend[k] = 0; m_cnt[k] = 0;
      end else if (m_pend[k] != 0) begin
        m_pc[k] = m_tgt[k];
        if (m_cnt[k] < cmax[k]) m_cnt[k] = m_cnt[k] + 1;
        m_pend[k] = 0;
        m_tv[k] = 0;
      end else begin
        if (br_valid) begin
          m_tgt[k]  = (int'(br_pc) + off * scale[k]) & 32'hFFFF;
          m_tv[k]   = 1;
          m_pend[k] = br_taken ? 1 : 0;
        end else begin
          m_tv[k] = 0;
        end
        if (jmp_valid)   m_pc[k] = int'(jmp_addr);
        else if (!stall) m_pc[k] = (m_pc[k] + 1) & 32'hFFFF;
      end
    end
  endfunction

  task automatic compare_all();
    check("pc0", 32'(if0.pc), m_pc[0]);
    check("pc_plus0", 32'(if0.pc_plus), (m_pc[0] + 1) & 32'hFFFF);
    check("target0", 32'(if0.target), m_tgt[0]);
    check("tvalid0", 32'(if0.target_valid), m_tv[0]);
    check("flush0", 32'(if0.flush), m_pend[0]);
    check("cnt0", 32'(if0.redirect_cnt), m_cnt[0]);
    check("pc1", 32'(if1.pc), m_pc[1]);
    check("pc_plus1", 32'(if1.pc_plus), (m_pc[1] + 1) & 32'hFFFF);
    check("target1", 32'(if1.target), m_tgt[1]);
    check("tvalid1", 32'(if1.target_valid), m_tv[1]);
    check("flush1", 32'(if1.flush), m_pend[1]);
    check("cnt1", 32'(if1.redirect_cnt), m_cnt[1]);
  endtask

  // One clock edge: model follows the inputs the DUT sampled, then compare.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    rst = 1'b0; stall = 1'b0; br_valid = 1'b0; br_taken = 1'b0;
    jmp_valid = 1'b0; br_pc = '0; br_offset = '0; jmp_addr = '0;
  endtask

  task automatic branch(input logic [15:0] bpc, input logic [15:0] off, input logic tk);
    br_valid = 1'b1; br_taken = tk; br_pc = bpc; br_offset = off;
  endtask

  logic [15:0] held_pc;

  initial begin
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 0; m_tgt[k] = 0; m_tv[k] = 0; m_pend[k] = 0; m_cnt[k] = 0;
    end

    // Reset: two cycles, then pc counts 1,2,3
    rst = 1'b1;
    @(posedge clk); model_step(); #1;
    tick();
    check("rst_pc", 32'(if0.pc), 32'h0);
    check("rst_pc_plus", 32'(if0.pc_plus), 32'h1);
    check("rst_flush", 32'(if0.flush), 32'h0);
    check("rst_tvalid", 32'(if0.target_valid), 32'h0);
    check("rst_cnt", 32'(if0.redirect_cnt), 32'h0);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("step_pc", 32'(if0.pc), 32'(i));
      check("step_pc_plus", 32'(if0.pc_plus), 32'(i + 1));
    end

    // Forward taken branch
    branch(16'h0010, 16'h0005, 1'b1);
    tick();
    check("fwd_target", 32'(if0.target), 32'h0015);
    check("fwd_tvalid", 32'(if0.target_valid), 32'h1);
    check("fwd_flush", 32'(if0.flush), 32'h1);
    idle_inputs();
    tick();
    check("fwd_pc", 32'(if0.pc), 32'h0015);
    check("fwd_flush_off", 32'(if0.flush), 32'h0);
    check("fwd_cnt", 32'(if0.redirect_cnt), 32'h1);

    // Wrap and scaling (not-taken captures)
    branch(16'h0002, 16'hFFFC, 1'b0);
    tick();
    check("wrap_low", 32'(if0.target), 32'hFFFE);
    branch(16'hFFFF, 16'h0003, 1'b0);
    tick();
    check("wrap_high", 32'(if0.target), 32'h0002);
    branch(16'h0100, 16'hFFFF, 1'b0);
    tick();
    check("scaled_target", 32'(if1.target), 32'h00FC);
    check("unscaled_target", 32'(if0.target), 32'h00FF);

    // Not-taken branch under stall
    idle_inputs();
    tick();
    stall = 1'b1;
    held_pc = if0.pc;
    branch(16'h0040, 16'h0008, 1'b0);
    tick();
    check("stall_target", 32'(if0.target), 32'h0048);
    check("stall_tvalid", 32'(if0.target_valid), 32'h1);
    check("stall_flush", 32'(if0.flush), 32'h0);
    check("stall_pc", 32'(if0.pc), 32'(held_pc));
    br_valid = 1'b0;
    tick();
    check("stall_tvalid_off", 32'(if0.target_valid), 32'h0);
    check("stall_pc2", 32'(if0.pc), 32'(held_pc));
    stall = 1'b0;
    tick();
    check("resume_pc", 32'(if0.pc), 32'(held_pc + 16'd1));

    // Collision in PEND cycle
    branch(16'h0200, 16'h0010, 1'b1);
    tick();
    jmp_valid = 1'b1; jmp_addr = 16'h0300; stall = 1'b1;
    branch(16'h0500, 16'h0001, 1'b1);
    tick();
    check("coll_pc", 32'(if0.pc), 32'h0210);
    check("coll_target", 32'(if0.target), 32'h0210);
    check("coll_flush", 32'(if0.flush), 32'h0);
    check("coll_cnt", 32'(if0.redirect_cnt), 32'h2);
    idle_inputs();
    tick();
    check("coll_after_pc", 32'(if0.pc), 32'h0211);

    // Reset during PEND
    branch(16'h0020, 16'h0004, 1'b1);
    tick();
    idle_inputs();
    rst = 1'b1;
    tick();
    check("rstp_pc", 32'(if0.pc), 32'h0);
    check("rstp_flush", 32'(if0.flush), 32'h0);
    check("rstp_cnt", 32'(if0.redirect_cnt), 32'h0);
    rst = 1'b0;

    // Counter saturation: five redirects
    for (int i = 0; i < 5; i++) begin
      branch(16'h1000, 16'(i), 1'b1);
      tick();
      idle_inputs();
      tick();
    end
    check("sat_cnt2", 32'(if1.redirect_cnt), 32'h3);
    check("sat_cnt8", 32'(if0.redirect_cnt), 32'h5);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      br_valid  = ($urandom_range(0, 2) == 0);
      br_taken  = $urandom_range(0, 1) == 1;
      br_pc     = 16'($urandom);
      br_offset = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 15) - 8);
      jmp_valid = ($urandom_range(0, 7) == 0);
      jmp_addr  = 16'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Parametrised program-counter and branch-target unit for the pipelined datapath. It holds the fetch PC and computes branch targets as base PC plus a sign-extended, optionally scaled offset. The target is registered for one cycle and, when the branch is taken, redirects the PC and flushes the fetch path. It sits between decode/execute and the instruction-memory address port, and keeps a saturating count of taken redirects.

## Interface
- WIDTH, 16: PC / address width.
- OFF_WIDTH, 16: branch offset width; must be ≤ WIDTH.
- OFF_SHIFT, 0: left shift applied to the sign-extended offset (0 = unit addressing, 1 = halfword, 2 = word).
- INC, 1: sequential PC increment.
- RESET_PC, 0: PC value loaded on reset.
- CNT_WIDTH, 8: redirect counter width.

- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC (sequential path only).
- br_valid  in  1  branch resolved this cycle.
- br_taken  in  1  branch outcome; qualified by br_valid.
- br_pc  in  WIDTH  PC of the branch instruction.
- br_offset  in  OFF_WIDTH  signed offset.
- jmp_valid  in  1  absolute jump request.
- jmp_addr  in  WIDTH  jump destination.
- pc  out  WIDTH  current fetch PC (register).
- pc_plus  out  WIDTH  pc + INC, modulo 2^WIDTH (combinational).
- target  out  WIDTH  last computed branch target (register).
- target_valid  out  1  target register holds a fresh result.
- flush  out  1  fetch-stage instruction is wrong-path; discard.
- redirect_cnt  out  CNT_WIDTH  saturating count of taken-branch redirects.

## Operation
- Target arithmetic: target = br_pc + (sext(br_offset) << OFF_SHIFT).
  - Computed in WIDTH bits and truncated modulo 2^WIDTH.
  - Wraps silently at both ends; no overflow flag.
- States:
  - IDLE: no branch pending.
  - PEND: registered taken branch awaiting redirect.
- Capture rule: on an edge with br_valid=1 and state≠PEND:
  - target and target_valid=1 are loaded.
  - The state moves to PEND if br_taken=1, and stays IDLE otherwise.
- Capture on edges without br_valid: target_valid clears to 0. target holds its value.
- PEND is a single cycle. The next edge always returns the state to IDLE.
- flush is high exactly while the state is PEND. It is driven directly from the state register.
- Next-PC priority, evaluated at each edge (highest first):
  1. rst: pc=RESET_PC.
  2. PEND: pc=target. redirect_cnt increments, saturating at all-ones.
  3. jmp_valid: pc=jmp_addr.
  4. stall: pc holds.
  5. Otherwise: pc=pc_plus.
- In PEND, the following are ignored: stall, jmp_valid, and br_valid.
  - These requests come from the wrong path, which is being flushed.
  - The ignored br_valid does not update target or target_valid.
- stall does not block branch capture; target registers update while stalled.
- Reset values: pc=RESET_PC, target=0, target_valid=0, state IDLE (flush=0), redirect_cnt=0.
- Because pc_plus follows pc, its reset value is RESET_PC+INC.

## Timing
- br_valid sampled at edge N:
  - target and target_valid are visible in cycle N+1.
  - For a taken branch, flush is also high in cycle N+1 (exactly one cycle).
  - For a taken branch, pc=target from edge N+1 onward.
  - Taken-branch redirect latency: 2 edges from the br_valid sample to the new PC.
- jmp_valid sampled at edge N: pc=jmp_addr in cycle N+1, unless the state was PEND at edge N.
- Back-to-back branches: a br_valid in the PEND cycle is dropped. A br_valid in the following cycle is captured normally.
- Reset mid-operation: rst wins over every other input.
  - Any pending redirect is discarded.
  - flush=0 in the cycle after reset.
  - redirect_cnt does not increment.
- Outputs pc, target, target_valid, flush and redirect_cnt are registered or register-derived. pc_plus is combinational from pc.

## Test plan
- Reset:
  - Stimulus: rst high for 2 cycles, then low, with no requests.
  - Required: pc=0x0000 and all flags 0 during reset; pc then steps 0x0001, 0x0002, 0x0003; pc_plus leads pc by 1.
- Forward taken branch:
  - Stimulus: br_pc=0x0010, br_offset=0x0005, taken.
  - Required: target=0x0015, target_valid=1, flush=1 for exactly one cycle; next pc=0x0015; redirect_cnt=1.
- Wrap and scaling, WIDTH=16:
  - br_pc=0x0002, br_offset=0xFFFC gives target=0xFFFE.
  - br_pc=0xFFFF, br_offset=0x0003 gives target=0x0002.
  - With OFF_SHIFT=2, br_pc=0x0100, br_offset=0xFFFF gives target=0x00FC.
- Not-taken branch under stall:
  - Stimulus: stall=1, br_valid=1, br_taken=0, br_pc=0x0040, br_offset=0x0008.
  - Required: target=0x0048, target_valid=1 for one cycle, flush stays 0, pc holds; pc resumes incrementing when stall drops.
- Collision in PEND cycle:
  - Stimulus: jmp_valid=1 (jmp_addr=0x0300), stall=1 and a new br_valid taken, all in the PEND cycle.
  - Required: pc=pending target; jump and second branch dropped; target unchanged; redirect_cnt +1 only.
- Reset during PEND, plus counter saturation:
  - rst during PEND gives pc=RESET_PC, flush=0 next cycle, redirect_cnt=0.
  - With CNT_WIDTH=2, 5 taken branches leave redirect_cnt=3.
